// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-MM arbiter: shares one zero-latency memory slave between the CPU (M0)
// and an auxiliary master (M1), with fixed or round-robin tie breaking and burst-limited starvation control.
module mips_bus_arbiter #(
  parameter int RR_MODE   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  grant,
  output logic        protocol_error,
  output logic [1:0]  dbg_state
);

  localparam int              CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic            r_last;        // 0 = M0 owned last, 1 = M1 owned last
  logic            w_last_next;
  logic            r_perr;
  logic            w_perr_next;

  logic            w_req0;
  logic            w_req1;
  logic            w_own_req;
  logic            w_own_rdwr;
  logic            w_done;
  logic            w_burst_hit;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Handshake: a master holds its request (and address/data) until it sees waitrequest low;
  // the cycle the owner requests with s_waitrequest low is the completing cycle ("done").
  always_comb begin
    w_own_req  = 1'b0;
    w_own_rdwr = 1'b0;
    case (r_state)
      ST_OWN0: begin
        w_own_req  = w_req0;
        w_own_rdwr = m0_read & m0_write;
      end
      ST_OWN1: begin
        w_own_req  = w_req1;
        w_own_rdwr = m1_read & m1_write;
      end
      default: begin
        w_own_req  = 1'b0;
        w_own_rdwr = 1'b0;
      end
    endcase
  end

  assign w_done      = w_own_req & ~s_waitrequest;
  assign w_burst_hit = (int'(r_count) + 1) >= MAX_BURST;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_last  <= 1'b1;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_next;
      r_last  <= w_last_next;
      r_perr  <= w_perr_next;
    end
  end

  // Next state: a stalled owner (request held, slave stalling) never loses the bus.
  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    w_perr_next = r_perr | w_own_rdwr;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          if (RR_MODE != 0) w_next = r_last ? ST_OWN0 : ST_OWN1;
          else              w_next = ST_OWN0;
        end else if (w_req0) begin
          w_next = ST_OWN0;
        end else if (w_req1) begin
          w_next = ST_OWN1;
        end
      end
      ST_OWN0: begin
        w_last_next = 1'b0;
        if (!w_req0 && w_req1) begin
          w_next = ST_OWN1;
        end else if (w_done && w_req1 && ((RR_MODE != 0) || w_burst_hit)) begin
          w_next = ST_OWN1;
        end
      end
      ST_OWN1: begin
        w_last_next = 1'b1;
        // M1 is the secondary master: in fixed mode it yields on every completed transfer too.
        if (!w_req1 && w_req0) begin
          w_next = ST_OWN0;
        end else if (w_done && w_req0) begin
          w_next = ST_OWN0;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    if (w_next != r_state) begin
      w_count_next = '0;
    end else if (w_done && (r_count != MAX_CNT)) begin
      w_count_next = r_count + CW'(1);
    end else begin
      w_count_next = r_count;
    end
  end

  always_comb begin
    s_address      = 32'd0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = 32'd0;
    s_byteenable   = 4'd0;
    m0_waitrequest = 1'b1;
    m0_readdata    = 32'd0;
    m1_waitrequest = 1'b1;
    m1_readdata    = 32'd0;
    grant          = 2'b00;
    case (r_state)
      ST_OWN0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write & ~m0_read;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
        grant          = 2'b01;
      end
      ST_OWN1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write & ~m1_read;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
        grant          = 2'b10;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

  assign protocol_error = r_perr;
  assign dbg_state      = r_state;

endmodule
